// File: rtl/id_ex_operand_stage_if.sv
// Purpose: ID/EX bundle between the decode side and the operand stage.
//   Carries the stall/flush/forwarding controls, ID operands and control,
//   the registered EX outputs, id_hold and the stall statistics.
// Modports: master drives the ID side and observes EX; slave is the stage.
interface id_ex_operand_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned OP_W   = 6,
  parameter int unsigned CNT_W  = 16
);
  // ID side
  logic              stall;
  logic              flush;
  logic [1:0]        fwa;
  logic [1:0]        fwb;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] fw_ex;
  logic [DATA_W-1:0] fw_mem;
  logic [DATA_W-1:0] fw_wb;
  logic [DATA_W-1:0] imm_in;
  logic              use_imm_in;
  logic [OP_W-1:0]   op_in;
  logic [REG_W-1:0]  rd_in;
  logic              rw_in;
  logic              mem_rd_in;
  logic              mem_wr_in;
  logic              valid_in;
  // EX side
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_store;
  logic [DATA_W-1:0] ex_imm;
  logic [OP_W-1:0]   ex_op;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_rw;
  logic              ex_mem_rd;
  logic              ex_mem_wr;
  logic              ex_valid;
  logic              id_hold;
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall_err;

  modport master (
    output stall, flush, fwa, fwb, rf_a, rf_b, fw_ex, fw_mem, fw_wb,
           imm_in, use_imm_in, op_in, rd_in, rw_in, mem_rd_in, mem_wr_in, valid_in,
    input  ex_a, ex_b, ex_store, ex_imm, ex_op, ex_rd, ex_rw, ex_mem_rd,
           ex_mem_wr, ex_valid, id_hold, stall_cnt, stall_err
  );

  modport slave (
    input  stall, flush, fwa, fwb, rf_a, rf_b, fw_ex, fw_mem, fw_wb,
           imm_in, use_imm_in, op_in, rd_in, rw_in, mem_rd_in, mem_wr_in, valid_in,
    output ex_a, ex_b, ex_store, ex_imm, ex_op, ex_rd, ex_rw, ex_mem_rd,
           ex_mem_wr, ex_valid, id_hold, stall_cnt, stall_err
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// Purpose: ID/EX operand stage. Picks each operand from the register file or
//   a forwarded EX/MEM/WB result, registers operands and control into EX,
//   and inserts a bubble on stall, flush or an invalid ID slot. Tracks total
//   stall cycles (saturating) and flags stall runs longer than MAX_STALL.
// Ports: clk, rst_n (synchronous, active low), bus (slave side of the
//   ID/EX bundle; id_hold is combinational, everything else registered).
module id_ex_operand_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_W     = 4,
  parameter int unsigned OP_W      = 6,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  id_ex_operand_stage_if.slave  bus
);

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic              issue;

  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;
  logic [DATA_W-1:0] ex_store_q, ex_store_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [OP_W-1:0]   ex_op_q, ex_op_d;
  logic [REG_W-1:0]  ex_rd_q, ex_rd_d;
  logic              ex_rw_q, ex_rw_d;
  logic              ex_mem_rd_q, ex_mem_rd_d;
  logic              ex_mem_wr_q, ex_mem_wr_d;
  logic              ex_valid_q, ex_valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic              stall_err_q, stall_err_d;

  // Forwarding muxes: 00 rf, 01 EX, 10 MEM, 11 WB
  always_comb begin
    fwd_a = bus.rf_a;
    fwd_b = bus.rf_b;
    case (bus.fwa)
      2'b01:   fwd_a = bus.fw_ex;
      2'b10:   fwd_a = bus.fw_mem;
      2'b11:   fwd_a = bus.fw_wb;
      default: fwd_a = bus.rf_a;
    endcase
    case (bus.fwb)
      2'b01:   fwd_b = bus.fw_ex;
      2'b10:   fwd_b = bus.fw_mem;
      2'b11:   fwd_b = bus.fw_wb;
      default: fwd_b = bus.rf_b;
    endcase
  end

  assign issue = bus.valid_in & ~bus.stall & ~bus.flush;

  // Next EX contents: full load on issue, all-zero bubble otherwise
  always_comb begin
    ex_a_d      = '0;
    ex_b_d      = '0;
    ex_store_d  = '0;
    ex_imm_d    = '0;
    ex_op_d     = '0;
    ex_rd_d     = '0;
    ex_rw_d     = 1'b0;
    ex_mem_rd_d = 1'b0;
    ex_mem_wr_d = 1'b0;
    ex_valid_d  = 1'b0;
    if (issue) begin
      ex_a_d      = fwd_a;
      ex_b_d      = bus.use_imm_in ? bus.imm_in : fwd_b;
      ex_store_d  = fwd_b;
      ex_imm_d    = bus.imm_in;
      ex_op_d     = bus.op_in;
      ex_rd_d     = bus.rd_in;
      ex_rw_d     = bus.rw_in;
      ex_mem_rd_d = bus.mem_rd_in;
      ex_mem_wr_d = bus.mem_wr_in;
      ex_valid_d  = 1'b1;
    end
  end

  // Stall statistics: saturating total, consecutive-run length, sticky error
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    run_d       = '0;
    if (bus.stall) begin
      if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      run_d = (&run_q) ? run_q : run_q + CNT_W'(1);
    end
    stall_err_d = stall_err_q | (run_d > CNT_W'(MAX_STALL));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_store_q  <= '0;
      ex_imm_q    <= '0;
      ex_op_q     <= '0;
      ex_rd_q     <= '0;
      ex_rw_q     <= 1'b0;
      ex_mem_rd_q <= 1'b0;
      ex_mem_wr_q <= 1'b0;
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      run_q       <= '0;
      stall_err_q <= 1'b0;
    end else begin
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_store_q  <= ex_store_d;
      ex_imm_q    <= ex_imm_d;
      ex_op_q     <= ex_op_d;
      ex_rd_q     <= ex_rd_d;
      ex_rw_q     <= ex_rw_d;
      ex_mem_rd_q <= ex_mem_rd_d;
      ex_mem_wr_q <= ex_mem_wr_d;
      ex_valid_q  <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
      run_q       <= run_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign bus.ex_a      = ex_a_q;
  assign bus.ex_b      = ex_b_q;
  assign bus.ex_store  = ex_store_q;
  assign bus.ex_imm    = ex_imm_q;
  assign bus.ex_op     = ex_op_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.ex_rw     = ex_rw_q;
  assign bus.ex_mem_rd = ex_mem_rd_q;
  assign bus.ex_mem_wr = ex_mem_wr_q;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.stall_err = stall_err_q;

  // Flush redirects fetch, so it overrides the hold request
  assign bus.id_hold = bus.stall & ~bus.flush;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.DATA_W(32), .REG_W(4), .OP_W(6), .CNT_W(16)) bus ();
  id_ex_operand_stage_if #(.DATA_W(32), .REG_W(4), .OP_W(6), .CNT_W(2))  bus2 ();

  id_ex_operand_stage #(.DATA_W(32), .REG_W(4), .OP_W(6), .CNT_W(16), .MAX_STALL(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  id_ex_operand_stage #(.DATA_W(32), .REG_W(4), .OP_W(6), .CNT_W(2), .MAX_STALL(1)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.flush = 0; bus.fwa = 0; bus.fwb = 0;
    bus.rf_a = 0; bus.rf_b = 0; bus.fw_ex = 0; bus.fw_mem = 0; bus.fw_wb = 0;
    bus.imm_in = 0; bus.use_imm_in = 0; bus.op_in = 0; bus.rd_in = 0;
    bus.rw_in = 0; bus.mem_rd_in = 0; bus.mem_wr_in = 0; bus.valid_in = 0;
    bus2.stall = 0; bus2.flush = 0; bus2.fwa = 0; bus2.fwb = 0;
    bus2.rf_a = 0; bus2.rf_b = 0; bus2.fw_ex = 0; bus2.fw_mem = 0; bus2.fw_wb = 0;
    bus2.imm_in = 0; bus2.use_imm_in = 0; bus2.op_in = 0; bus2.rd_in = 0;
    bus2.rw_in = 0; bus2.mem_rd_in = 0; bus2.mem_wr_in = 0; bus2.valid_in = 0;
  endtask

  task automatic test_reset();
    bus.op_in = 6'h20; bus.rd_in = 4'd3; bus.rf_a = 32'd1; bus.rf_b = 32'd2;
    bus.rw_in = 1; bus.valid_in = 1; bus.imm_in = 32'h55;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_op !== 6'h20) begin
      errors++;
      $display("FAIL reset_preload: ex_valid=%0b ex_op=%h, want 1/20", bus.ex_valid, bus.ex_op);
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_rw !== 1'b0 || bus.ex_op !== 6'h0 || bus.ex_rd !== 4'h0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%0b rw=%0b op=%h rd=%h, want all 0",
               bus.ex_valid, bus.ex_rw, bus.ex_op, bus.ex_rd);
    end
    checks++;
    if (bus.ex_a !== 32'd0 || bus.ex_b !== 32'd0 || bus.ex_store !== 32'd0 || bus.ex_imm !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: a=%h b=%h st=%h imm=%h, want all 0",
               bus.ex_a, bus.ex_b, bus.ex_store, bus.ex_imm);
    end
    checks++;
    if (bus.stall_cnt !== 16'd0 || bus.stall_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_stats: cnt=%0d err=%0b, want 0/0", bus.stall_cnt, bus.stall_err);
    end
    clear_inputs();
  endtask

  task automatic test_forwarding();
    logic [31:0] exp_val [4];
    exp_val[0] = 32'd5; exp_val[1] = 32'd7; exp_val[2] = 32'd9; exp_val[3] = 32'd11;
    bus.rf_a = 32'd5; bus.rf_b = 32'd5; bus.fw_ex = 32'd7; bus.fw_mem = 32'd9; bus.fw_wb = 32'd11;
    bus.valid_in = 1; bus.op_in = 6'h20; bus.rd_in = 4'd4; bus.rw_in = 1;
    for (int i = 0; i < 4; i++) begin
      bus.fwa = 2'(i);
      bus.fwb = 2'(3 - i);
      tick();
      checks++;
      if (bus.ex_a !== exp_val[i]) begin
        errors++;
        $display("FAIL fwd_a sel=%0d: got %0d, want %0d", i, bus.ex_a, exp_val[i]);
      end
      checks++;
      if (bus.ex_b !== exp_val[3-i] || bus.ex_store !== exp_val[3-i] || bus.ex_valid !== 1'b1) begin
        errors++;
        $display("FAIL fwd_b sel=%0d: b=%0d st=%0d v=%0b, want %0d/%0d/1",
                 3 - i, bus.ex_b, bus.ex_store, bus.ex_valid, exp_val[3-i], exp_val[3-i]);
      end
    end
  endtask

  task automatic test_immediate();
    bus.use_imm_in = 1; bus.imm_in = 32'h10; bus.fwb = 2'b01; bus.fw_ex = 32'h22;
    tick();
    checks++;
    if (bus.ex_b !== 32'h10 || bus.ex_store !== 32'h22 || bus.ex_imm !== 32'h10) begin
      errors++;
      $display("FAIL immediate: b=%h st=%h imm=%h, want 10/22/10", bus.ex_b, bus.ex_store, bus.ex_imm);
    end
    bus.use_imm_in = 0;
  endtask

  task automatic test_load_use();
    bus.op_in = 6'h23; bus.rd_in = 4'd7; bus.rw_in = 1; bus.mem_rd_in = 1;
    bus.valid_in = 1; bus.fwa = 2'b00;
    bus.stall = 1;
    #1;
    checks++;
    if (bus.id_hold !== 1'b1) begin
      errors++;
      $display("FAIL load_use_hold: id_hold=%0b, want 1", bus.id_hold);
    end
    tick();
    exp_cnt++;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_rw !== 1'b0 || bus.ex_mem_rd !== 1'b0 || bus.ex_op !== 6'h0) begin
      errors++;
      $display("FAIL load_use_bubble: v=%0b rw=%0b mrd=%0b op=%h, want 0/0/0/00",
               bus.ex_valid, bus.ex_rw, bus.ex_mem_rd, bus.ex_op);
    end
    checks++;
    if (bus.stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL load_use_cnt: got %0d, want %0d", bus.stall_cnt, exp_cnt);
    end
    bus.stall = 0;
    bus.fwa = 2'b10;
    #1;
    checks++;
    if (bus.id_hold !== 1'b0) begin
      errors++;
      $display("FAIL load_use_release: id_hold=%0b, want 0", bus.id_hold);
    end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_a !== 32'd9 || bus.ex_op !== 6'h23 || bus.ex_mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL load_use_issue: v=%0b a=%0d op=%h mrd=%0b, want 1/9/23/1",
               bus.ex_valid, bus.ex_a, bus.ex_op, bus.ex_mem_rd);
    end
  endtask

  task automatic test_stall_flush();
    bus.stall = 1; bus.flush = 1;
    #1;
    checks++;
    if (bus.id_hold !== 1'b0) begin
      errors++;
      $display("FAIL stall_flush_hold: id_hold=%0b, want 0", bus.id_hold);
    end
    tick();
    exp_cnt++;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_rw !== 1'b0 || bus.stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL stall_flush: v=%0b rw=%0b cnt=%0d, want 0/0/%0d",
               bus.ex_valid, bus.ex_rw, bus.stall_cnt, exp_cnt);
    end
    bus.stall = 0; bus.flush = 0; bus.valid_in = 0;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_mem_rd !== 1'b0 || bus.stall_err !== 1'b0) begin
      errors++;
      $display("FAIL invalid_bubble: v=%0b mrd=%0b err=%0b, want 0/0/0",
               bus.ex_valid, bus.ex_mem_rd, bus.stall_err);
    end
  endtask

  task automatic test_long_stall();
    logic [2:0] exp_err;
    exp_err = 3'b110;
    bus.valid_in = 1;
    bus.stall = 1; bus2.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_cnt++;
      checks++;
      if (bus.stall_err !== exp_err[i]) begin
        errors++;
        $display("FAIL long_stall_err cycle=%0d: got %0b, want %0b", i + 1, bus.stall_err, exp_err[i]);
      end
    end
    bus.stall = 0;
    tick();
    tick();
    bus2.stall = 0;
    tick();
    checks++;
    if (bus.stall_err !== 1'b1 || bus.stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL long_stall_sticky: err=%0b cnt=%0d, want 1/%0d", bus.stall_err, bus.stall_cnt, exp_cnt);
    end
    checks++;
    if (bus2.stall_cnt !== 2'd3 || bus2.stall_err !== 1'b1) begin
      errors++;
      $display("FAIL cnt_saturate: cnt=%0d err=%0b, want 3/1", bus2.stall_cnt, bus2.stall_err);
    end
    checks++;
    if (bus.ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_stall_issue: v=%0b, want 1", bus.ex_valid);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    test_reset();
    test_forwarding();
    test_immediate();
    test_load_use();
    test_stall_flush();
    test_long_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
